reaction_responder: RTL and testbench

Automated player for the reaction tester: it drives the tester's request and stop keys and watches its test-active LED, standing in for the human. A trial runs on a `start` pulse:

- press request;
- wait for the LED;
- wait a programmed reaction delay;
- press stop;
- report the LED-high duration.

It sits beside the tester in self-test builds, and its key outputs are muxed onto the tester's KEY[1]/KEY[2] inputs.

---
 rtl/reaction_responder_pkg.sv | 28 ++
 rtl/reaction_responder_timer.sv | 27 ++
 rtl/reaction_responder.sv | 157 +++++++++++++++
 tb/tb_reaction_responder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_responder_pkg.sv
// Shared definitions for the reaction-tester auto-player: one-hot state encoding
// and default key-press / LED-timeout durations, also used by tester-level benches.
package reaction_responder_pkg;

    localparam int DEF_PRESS_CYCLES   = 50000;      // 1 ms at 50 MHz
    localparam int DEF_TIMEOUT_CYCLES = 300000000;  // 6 s at 50 MHz

    localparam int IDX_IDLE     = 0;
    localparam int IDX_REQ      = 1;
    localparam int IDX_WAIT_LED = 2;
    localparam int IDX_REACT    = 3;
    localparam int IDX_STOP     = 4;
    localparam int IDX_DONE     = 5;

    typedef enum logic [5:0] {
        S_IDLE     = 6'b000001,
        S_REQ      = 6'b000010,
        S_WAIT_LED = 6'b000100,
        S_REACT    = 6'b001000,
        S_STOP     = 6'b010000,
        S_DONE     = 6'b100000
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reaction_responder_timer.sv
// Loadable down-counter; zero flags the last cycle of a loaded duration
// (load N-1 on state entry to stay N cycles in that state).
module cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk_sys,
    input  logic         rst_b,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/reaction_responder.sv
// Automated player for the reaction tester: presses request, waits for the LED,
// waits the programmed reaction delay, presses stop and reports LED-high time.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | keys released, waiting for start
// REQ      | request key held for PRESS_CYCLES
// WAIT_LED | keys released, waiting for LED (bounded by TIMEOUT_CYCLES)
// REACT    | LED seen, waiting the latched reaction delay
// STOP     | stop key held for PRESS_CYCLES
// DONE     | one-cycle completion pulse
module reaction_responder
    import reaction_responder_pkg::*;
#(
    parameter int PRESS_CYCLES   = DEF_PRESS_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int DELAY_W        = 26,
    parameter int CNT_W          = 32
) (
    input  logic               CLOCK_50,
    input  logic               resetn,
    input  logic               start,
    input  logic               led_in,
    input  logic [DELAY_W-1:0] reaction_cycles,
    output logic               key_req_n,
    output logic               key_stop_n,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [CNT_W-1:0]   led_cycles
);

    localparam int TW = max_int($clog2(TIMEOUT_CYCLES), DELAY_W);

    state_t             state, state_next;
    logic               tmr_load, tmr_zero;
    logic [TW-1:0]      tmr_val;
    logic               start_acc, to_evt;
    logic [DELAY_W-1:0] delay_q;
    logic               timeout_q, to_pulse_q, led_ended_q, led_count_en;
    logic [CNT_W-1:0]   led_cnt;

    cycle_timer #(.W(TW)) u_timer (
        .clk_sys  (CLOCK_50),
        .rst_b    (resetn),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        start_acc  = 1'b0;
        to_evt     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    start_acc  = 1'b1;
                    state_next = S_REQ;
                    tmr_load   = 1'b1;
                    tmr_val    = TW'(PRESS_CYCLES - 1);
                end
            end
            S_REQ: begin
                if (tmr_zero) begin
                    state_next = S_WAIT_LED;
                    tmr_load   = 1'b1;
                    tmr_val    = TW'(TIMEOUT_CYCLES - 1);
                end
            end
            S_WAIT_LED: begin
                // LED takes priority over a timeout expiring in the same cycle
                if (led_in) begin
                    tmr_load = 1'b1;
                    if (delay_q == '0) begin
                        state_next = S_STOP;
                        tmr_val    = TW'(PRESS_CYCLES - 1);
                    end else begin
                        state_next = S_REACT;
                        tmr_val    = TW'(delay_q) - TW'(1);
                    end
                end else if (tmr_zero) begin
                    state_next = S_IDLE;
                    to_evt     = 1'b1;
                end
            end
            S_REACT: begin
                if (tmr_zero) begin
                    state_next = S_STOP;
                    tmr_load   = 1'b1;
                    tmr_val    = TW'(PRESS_CYCLES - 1);
                end
            end
            S_STOP: begin
                if (tmr_zero) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // A falling LED once past WAIT_LED ends the measurement for this trial.
    assign led_count_en = led_in & ~led_ended_q
                        & (state[IDX_WAIT_LED] | state[IDX_REACT] | state[IDX_STOP]);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            delay_q     <= '0;
            timeout_q   <= 1'b0;
            to_pulse_q  <= 1'b0;
            led_ended_q <= 1'b0;
            led_cnt     <= '0;
        end else begin
            to_pulse_q <= to_evt;
            if (start_acc) begin
                delay_q     <= reaction_cycles;
                timeout_q   <= 1'b0;
                led_ended_q <= 1'b0;
                led_cnt     <= '0;
            end else begin
                if (to_evt) begin
                    timeout_q <= 1'b1;
                end
                if ((state[IDX_REACT] | state[IDX_STOP]) && !led_in) begin
                    led_ended_q <= 1'b1;
                end
                if (led_count_en && (led_cnt != {CNT_W{1'b1}})) begin
                    led_cnt <= led_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign key_req_n  = ~state[IDX_REQ];
    assign key_stop_n = ~state[IDX_STOP];
    assign busy       = ~state[IDX_IDLE];
    assign done       = state[IDX_DONE] | to_pulse_q;
    assign timeout    = timeout_q;
    assign led_cycles = led_cnt;

endmodule

// File: tb/tb_reaction_responder.sv
// Directed bench for reaction_responder with short press/timeout durations;
// expected trial results are queued at stimulus time and checked on done.
module tb_reaction_responder;

    localparam int P  = 4;
    localparam int TO = 100;
    localparam int DW = 26;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic          led_in = 1'b0;
    logic [DW-1:0] reaction_cycles = '0;
    logic          key_req_n, key_stop_n, busy, done, timeout;
    logic [CW-1:0] led_cycles;

    typedef struct {
        int cnt;
        int done_cyc;
        bit to;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   req_low_total = 0;
    int   stop_low_total = 0;
    int   done_total = 0;

    reaction_responder #(
        .PRESS_CYCLES   (P),
        .TIMEOUT_CYCLES (TO),
        .DELAY_W        (DW),
        .CNT_W          (CW)
    ) dut (
        .CLOCK_50        (clk),
        .resetn          (resetn),
        .start           (start),
        .led_in          (led_in),
        .reaction_cycles (reaction_cycles),
        .key_req_n       (key_req_n),
        .key_stop_n      (key_stop_n),
        .busy            (busy),
        .done            (done),
        .timeout         (timeout),
        .led_cycles      (led_cycles)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (key_req_n === 1'b0)  req_low_total  <= req_low_total + 1;
        if (key_stop_n === 1'b0) stop_low_total <= stop_low_total + 1;
        if (done === 1'b1)       done_total     <= done_total + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag, input int dcyc);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_done_cyc"}, 64'(dcyc), 64'(e.done_cyc));
            check({tag, "_led_cycles"}, 64'(led_cycles), 64'(e.cnt));
            check({tag, "_timeout"}, 64'(timeout), 64'(e.to));
        end
    endtask

    // One full trial; poke pulses start in REQ, REACT (r>=2) and DONE.
    task automatic run_trial(input string tag, input int r, input int led_dly,
                             input int drop_d, input bit poke);
        int s, w, t0, f, req0, stop0, done0, ec;
        bit got;
        exp_t e;
        req0  = req_low_total;
        stop0 = stop_low_total;
        done0 = done_total;
        f     = -1;
        got   = 1'b0;
        reaction_cycles = DW'(r);
        start = 1'b1;
        s = cyc;
        tick();
        start = 1'b0;
        check({tag, "_req_first"}, 64'(key_req_n), 64'd0);
        check({tag, "_busy_first"}, 64'(busy), 64'd1);
        check({tag, "_timeout_clr"}, 64'(timeout), 64'd0);
        for (int i = 2; i <= P; i++) begin
            tick();
            start = poke && (i == 2);
            if (poke && i == 2) reaction_cycles = DW'(r + 7);
        end
        check({tag, "_req_last"}, 64'(key_req_n), 64'd0);
        tick();
        w = s + P + 1;
        check({tag, "_req_release"}, 64'(key_req_n), 64'd1);
        repeat (led_dly) tick();
        led_in = 1'b1;
        t0 = cyc;
        ec = (drop_d < P) ? (r + 1 + drop_d) : (r + 1 + P);
        e.cnt = ec;
        e.done_cyc = t0 + r + P + 1;
        e.to = 1'b0;
        sb.push_back(e);
        for (int i = 0; i < 300 && !got; i++) begin
            tick();
            start = poke && ((cyc == t0 + 2) || (cyc == t0 + r + P + 1));
            if (key_stop_n === 1'b0 && f < 0) f = cyc;
            if (f >= 0 && cyc == f + drop_d) led_in = 1'b0;
            if (done === 1'b1) got = 1'b1;
        end
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        check({tag, "_stop_fall"}, 64'(f), 64'(t0 + r + 1));
        check({tag, "_busy_in_done"}, 64'(busy), 64'd1);
        sb_check(tag, cyc);
        led_in = 1'b0;
        reaction_cycles = DW'(r);
        tick();
        start = 1'b0;
        check({tag, "_busy_release"}, 64'(busy), 64'd0);
        check({tag, "_no_restart"}, 64'(key_req_n), 64'd1);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        tick();
        tick();
        check({tag, "_req_len"}, 64'(req_low_total - req0), 64'(P));
        check({tag, "_stop_len"}, 64'(stop_low_total - stop0), 64'(P));
        check({tag, "_done_count"}, 64'(done_total - done0), 64'd1);
        if (w < 0) check({tag, "_entry"}, 64'd0, 64'd1);
    endtask

    initial begin
        int s, w, stop0, done0;
        bit got;
        exp_t e;

        // reset state
        tick();
        tick();
        check("rst_key_req_n", 64'(key_req_n), 64'd1);
        check("rst_key_stop_n", 64'(key_stop_n), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        check("rst_led_cycles", 64'(led_cycles), 64'd0);
        resetn = 1'b1;
        tick();
        tick();

        run_trial("nominal", 10, 20, 2, 1'b0);

        // LED timeout
        stop0 = stop_low_total;
        done0 = done_total;
        got = 1'b0;
        reaction_cycles = DW'(5);
        start = 1'b1;
        s = cyc;
        tick();
        start = 1'b0;
        w = s + P + 1;
        e.cnt = 0;
        e.done_cyc = w + TO;
        e.to = 1'b1;
        sb.push_back(e);
        for (int i = 0; i < 400 && !got; i++) begin
            tick();
            if (done === 1'b1) got = 1'b1;
        end
        check("timeout_done_seen", 64'(got), 64'd1);
        check("timeout_busy", 64'(busy), 64'd0);
        sb_check("timeout", cyc);
        tick();
        check("timeout_done_pulse", 64'(done), 64'd0);
        check("timeout_sticky", 64'(timeout), 64'd1);
        tick();
        check("timeout_no_stop", 64'(stop_low_total - stop0), 64'd0);
        check("timeout_done_count", 64'(done_total - done0), 64'd1);

        run_trial("zero_delay", 0, 3, 100, 1'b0);

        // reset while the stop key is held
        reaction_cycles = DW'(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (P + 2) tick();
        led_in = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            tick();
            if (key_stop_n === 1'b0) got = 1'b1;
        end
        check("rstmid_stop_seen", 64'(got), 64'd1);
        tick();
        #1 resetn = 1'b0;
        #1;
        check("rstmid_key_req_n", 64'(key_req_n), 64'd1);
        check("rstmid_key_stop_n", 64'(key_stop_n), 64'd1);
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_led_cycles", 64'(led_cycles), 64'd0);
        led_in = 1'b0;
        tick();
        resetn = 1'b1;
        tick();

        run_trial("after_reset", 2, 5, 1, 1'b0);
        run_trial("start_busy", 6, 4, 1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
